// File: rtl/calc_ctrl_if.sv
// Token, ALU and result bundle between calc_ctrl and its neighbours.
// The master side is the front-end, the ALU and the result consumer; the slave side is calc_ctrl.
interface calc_ctrl_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_op;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic [7:0]       op_count;

  modport master (
    output in_valid, in_is_op, in_data, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_err, op_count
  );

  modport slave (
    input  in_valid, in_is_op, in_data, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_err, op_count
  );
endinterface

// File: rtl/calc_ctrl.sv
// Sequences operand A, opcode and operand B tokens into the 4-bit ALU.
// It then offers the captured result, or an error flag, on a valid/ready handshake.
module calc_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  calc_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_OP,
    WAIT_B,
    EXEC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             err_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       sel_q;
  logic             out_err_q;
  logic [7:0]       count_q;

  logic in_ready, out_valid, accept, tok_ok;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_A;
    else     state_q <= state_d;
  end

  // tok_ok says whether the offered token is the one this state expects.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    tok_ok    = 1'b0;
    case (state_q)
      WAIT_A: begin
        in_ready = !rst;
        tok_ok   = !bus.in_is_op;
        if (bus.in_valid && in_ready) state_d = tok_ok ? WAIT_OP : EXEC;
      end
      WAIT_OP: begin
        in_ready = !rst;
        tok_ok   = bus.in_is_op && !bus.in_data[WIDTH-1];
        if (bus.in_valid && in_ready) state_d = tok_ok ? WAIT_B : EXEC;
      end
      WAIT_B: begin
        in_ready = !rst;
        tok_ok   = !bus.in_is_op;
        if (bus.in_valid && in_ready) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // A rejected token still takes the EXEC slot, so err_q marks that pass as an error pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      out_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (accept) begin
        err_q <= !tok_ok;
        if (tok_ok) begin
          case (state_q)
            WAIT_A:  a_q   <= bus.in_data;
            WAIT_OP: sel_q <= bus.in_data[2:0];
            WAIT_B:  b_q   <= bus.in_data;
            default: ;
          endcase
        end
      end
      if (state_q == EXEC) begin
        err_q <= 1'b0;
        if (err_q) begin
          result_q  <= '0;
          out_err_q <= 1'b1;
        end else begin
          result_q  <= bus.alu_result;
          out_err_q <= 1'b0;
          count_q   <= count_q + 8'd1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_sel    = sel_q;
  assign bus.out_result = result_q;
  assign bus.out_err    = out_err_q;
  assign bus.op_count   = count_q;

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Operand/opcode sequencer that drives the 4-bit ALU from a token stream. Accepts tokens over a valid/ready input handshake in the order operand A, opcode, operand B. Drives registered `alu_a`/`alu_b`/`alu_sel` into the combinational ALU and captures `alu_result`. Presents the result on a valid/ready output handshake. Sits between the front-end input logic (keypad/UART decoder) and the display/result consumer.

## Interface
- `WIDTH`, 4, operand/result width; must equal ALU width (only 4 supported).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  token present.
- `in_ready`  out  1  controller accepts token this cycle.
- `in_is_op`  in  1  1 = opcode token, 0 = operand token.
- `in_data`  in  4  operand value, or opcode in [2:0] with [3] required 0.
- `alu_a`  out  4  registered operand A to ALU.
- `alu_b`  out  4  registered operand B to ALU.
- `alu_sel`  out  3  registered opcode to ALU (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 PASS B, 111 zero).
- `alu_result`  in  4  combinational ALU output.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  4  captured result.
- `out_err`  out  1  sequence error flag, qualified by `out_valid`.
- `op_count`  out  8  count of successful (non-error) results, wraps.

## Operation
- States: WAIT_A, WAIT_OP, WAIT_B, EXEC, DONE. Reset → WAIT_A.
- Token handshake: a token is accepted on an edge where `in_valid & in_ready`.
- `in_ready` = 1 in WAIT_A/WAIT_OP/WAIT_B, 0 in EXEC/DONE, and 0 while `rst` is high.
- WAIT_A:
  - Operand token → `alu_a` <= data, go to WAIT_OP.
  - Opcode token → error.
- WAIT_OP:
  - Opcode token with `in_data[3]`=0 → `alu_sel` <= data[2:0], go to WAIT_B.
  - Operand token, or `in_data[3]`=1 → error.
- WAIT_B:
  - Operand token → `alu_b` <= data, go to EXEC.
  - Opcode token → error.
- EXEC (exactly one cycle): ALU inputs stable. At the edge: `out_result` <= `alu_result`, `out_err` <= 0, `op_count` += 1, go to DONE.
- Error path: the offending token is consumed. Then `out_result` <= 0, `out_err` <= 1, go to DONE. `op_count` does not change. `alu_a`/`alu_b`/`alu_sel` keep their last values.
- DONE:
  - `out_valid` = 1.
  - `out_result`/`out_err` stay stable until an edge with `out_ready`=1; that edge is the handshake. Then go to WAIT_A.
- Arithmetic is the ALU's, modulo 16; no carry/borrow is reported.
- `op_count`: 8-bit, 255 + 1 → 0.
- After a handshake, `out_result`/`out_err` keep their last values; `out_valid` drops.

## Timing
- Reset values: `in_ready` 0 during reset, `alu_a`/`alu_b`/`alu_sel` 0, `out_valid` 0, `out_result` 0, `out_err` 0, `op_count` 0.
- `in_ready` = 1 from the first cycle after `rst` deasserts.
- B accepted at edge k → EXEC during cycle k+1 → `out_valid` = 1 after edge k+1. Latency from B acceptance to `out_valid` is 2 edges.
- Error token accepted at edge k → `out_valid` = 1 after edge k+1. The controller passes through EXEC-equivalent timing: one cycle, no ALU capture.
- Output handshake at edge m → `out_valid` 0 and `in_ready` 1 after edge m.
- Maximum throughput: one result per 5 cycles (A, op, B, EXEC, DONE with `out_ready` held high).
- `in_valid` with `in_ready`=0 has no effect. The producer must hold the token until it is accepted; the controller never drops an unaccepted token.
- `out_ready` is ignored outside DONE.
- `rst` asserted in any state, including mid-sequence or while `out_valid`=1:
  - Next state is WAIT_A and all outputs take their reset values.
  - A partially entered sequence is discarded.
  - The token offered in the reset cycle is not accepted.
- `alu_*` outputs change only on token-acceptance edges, so the ALU sees stable inputs for the full EXEC cycle.

## Test plan
- Tokens A=5, op=000, B=3, `out_ready`=1 → `out_valid`=1 two edges after B with `out_result`=8, `out_err`=0, `op_count`=1, `alu_sel`=000.
- Tokens A=3, op=001, B=5 → `out_result`=0xE. Also A=0xA, op=101, B=0 → `out_result`=0x5.
- Opcode token first in WAIT_A (data=2) → token consumed; `out_valid` with `out_err`=1, `out_result`=0; `op_count` unchanged. Repeat with op token data=0xF in WAIT_OP → same error response.
- Backpressure: `out_ready`=0 for 4 cycles after `out_valid` → `out_result` stable, `in_ready`=0 throughout. `out_ready`=1 → `out_valid` drops next cycle and `in_ready`=1.
- Reset asserted in WAIT_B after A=7, op=011 → all outputs 0. The next sequence A=1, op=110, B=9 yields `out_result`=9, not affected by the earlier A.
- Run 256 back-to-back successful sequences → `op_count` reaches 255 and then wraps to 0. Interleaved error sequences do not increment `op_count`.
